// File: rtl/threshold_fifo.sv
// rtl/threshold_fifo.sv - show-ahead FIFO with occupancy thresholds and sticky error flags
//   clk                          rising-edge clock
//   reset_n                      asynchronous active-low reset
//   flush                        synchronous discard of all queued entries
//   write_en / write_data        push request and data
//   read_en / read_data          pop request and head entry (zero-latency show-ahead)
//   full / empty                 occupancy == NUM_ENTRIES / occupancy == 0
//   almost_full / almost_empty   count >= ALMOST_FULL_THRESHOLD / count <= ALMOST_EMPTY_THRESHOLD
//   count                        current occupancy
//   overflow / underflow         sticky flags for rejected push / pop
//   error_clear                  synchronous clear of overflow and underflow
module threshold_fifo #(
  parameter int WIDTH                  = 32,
  parameter int NUM_ENTRIES            = 8,
  parameter int ALMOST_FULL_THRESHOLD  = NUM_ENTRIES - 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             write_en,
  input  logic [WIDTH-1:0]                 write_data,
  input  logic                             read_en,
  output logic [WIDTH-1:0]                 read_data,
  output logic                             full,
  output logic                             empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] count,
  output logic                             overflow,
  output logic                             underflow,
  input  logic                             error_clear
);

  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int PW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_ENTRIES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_THRESHOLD);
  localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_THRESHOLD);

  logic [WIDTH-1:0] mem [NUM_ENTRIES];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Flags come only from the count register, so no input reaches them combinationally.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Acceptance uses the pre-edge full/empty: a pop never frees room for a same-cycle push,
  // and a push never supplies data for a same-cycle pop.
  assign push_ok = write_en & ~flush & ~full;
  assign pop_ok  = read_en  & ~flush & ~empty;

  assign read_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= next_ptr(wr_ptr);
        if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
        if (push_ok && !pop_ok)      count <= count + 1'b1;
        else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
      // A new error in the same cycle as error_clear keeps the flag set.
      overflow  <= (write_en & full  & ~flush) | (overflow  & ~error_clear);
      underflow <= (read_en  & empty & ~flush) | (underflow & ~error_clear);
    end
  end

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= write_data;
  end

endmodule

// File: tb/tb_threshold_fifo.sv
// tb/tb_threshold_fifo.sv - randomized bench for threshold_fifo against a queue model
module tb_threshold_fifo;

  localparam int WIDTH = 8;
  localparam int N     = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             full, empty, almost_full, almost_empty;
  logic [CW-1:0]    count;
  logic             overflow, underflow;
  logic             error_clear;

  threshold_fifo #(
    .WIDTH(WIDTH), .NUM_ENTRIES(N),
    .ALMOST_FULL_THRESHOLD(AF), .ALMOST_EMPTY_THRESHOLD(AE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents plus the two sticky error bits.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_udf;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == N));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    if (q.size() > 0) check({tag, ".read_data"}, 32'(read_data), 32'(q[0]));
  endtask

  // One clock with the given inputs; model advances at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag, input bit we, input logic [WIDTH-1:0] wd,
                      input bit re, input bit fl, input bit ec);
    bit was_full, was_empty;
    write_en    = we;
    write_data  = wd;
    read_en     = re;
    flush       = fl;
    error_clear = ec;
    @(posedge clk);
    was_full  = (q.size() == N);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
    end else begin
      if (re && !was_empty) void'(q.pop_front());
      if (we && !was_full)  q.push_back(wd);
    end
    if (we && was_full && !fl) m_ovf = 1'b1;
    else if (ec)               m_ovf = 1'b0;
    if (re && was_empty && !fl) m_udf = 1'b1;
    else if (ec)                m_udf = 1'b0;
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, confirm it takes effect without a clock, release away from the edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    check_all({tag, ".async"});
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    flush       = 1'b0;
    write_en    = 1'b0;
    write_data  = '0;
    read_en     = 1'b0;
    error_clear = 1'b0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;
    #3;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_held");
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Fill 0x11..0x55 then drain in order.
    for (int i = 1; i <= 5; i++) step("fill", 1, WIDTH'(i * 8'h11), 0, 0, 0);
    for (int i = 0; i < 5; i++)  step("drain", 0, '0, 1, 0, 0);

    // Bursts of three across pointer wrap.
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 3; i++) step("wrap_push", 1, WIDTH'(b * 3 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step("wrap_pop", 0, '0, 1, 0, 0);
      check("wrap_max", 32'(count <= 3), 32'd1);
    end

    // Push+pop while full: pop taken, 0x99 rejected.
    for (int i = 0; i < 5; i++) step("pre_full", 1, WIDTH'(8'hA0 + i), 0, 0, 0);
    step("full_both", 1, 8'h99, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("full_drain", 0, '0, 1, 0, 0);
    step("clr_ovf", 0, '0, 0, 0, 1);

    // Push+pop while empty: push taken, pop flagged.
    step("empty_both", 1, 8'h42, 1, 0, 0);
    step("clr_udf", 0, '0, 0, 0, 1);
    step("pop42", 0, '0, 1, 0, 0);

    // Error clear coinciding with a new error keeps the flag.
    step("udf_again", 0, '0, 1, 0, 0);
    step("set_wins", 0, '0, 1, 0, 1);
    step("clr_udf2", 0, '0, 0, 0, 1);

    // Flush with count=3 and a same-cycle push.
    for (int i = 0; i < 3; i++) step("pre_flush", 1, WIDTH'(8'hC0 + i), 0, 0, 0);
    step("err_before_flush", 0, '0, 1, 0, 0);
    step("refill", 1, 8'hC5, 0, 0, 0);
    step("flush", 1, 8'hEE, 0, 1, 0);
    step("post_flush", 1, 8'h3C, 0, 0, 0);
    step("post_flush_pop", 0, '0, 1, 0, 1);

    // Reset between edges with count=2, then first push after release.
    step("pre_rst", 1, 8'h01, 0, 0, 0);
    step("pre_rst", 1, 8'h02, 0, 0, 0);
    mid_reset("rst_mid");
    step("rst_push", 1, 8'h7E, 0, 0, 0);
    step("rst_pop", 0, '0, 1, 0, 0);

    // Randomized traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      if ($urandom_range(0, 399) == 0) mid_reset("rnd_rst");
      step("rnd",
           $urandom_range(0, 99) < wp,
           WIDTH'($urandom),
           $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
